// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives the instruction memory address and
// fills the IF/ID register with stall, redirect and out-of-range halt handling.
module fetch_stage #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned IMEM_WORDS = 64,
   parameter logic [31:0] NOP_INSTR  = 32'hE1A0_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] imem_a,
   input  logic [31:0] imem_rd,
   input  logic        stall_d,
   input  logic        redirect_e,
   input  logic [31:0] redirect_target_e,
   output logic [31:0] instr_d,
   output logic [31:0] pc_d,
   output logic [31:0] pc_plus8_d,
   output logic        valid_d,
   output logic        fault_d,
   output logic        halted,
   output logic [31:0] fetch_count
);

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } state_t;

   state_t      state, state_nxt;
   logic [31:0] pc, pc_nxt;
   logic [31:0] instr_nxt, pcd_nxt, count_nxt;
   logic        valid_nxt, fault_nxt;
   logic        advance, in_range;

   // A bubble in IF/ID never blocks fetch; only a valid, stalled slot does.
   assign advance    = !stall_d || !valid_d;
   assign in_range   = {2'b00, pc[31:2]} < 32'(IMEM_WORDS);
   assign imem_a     = pc;
   assign pc_plus8_d = pc_d + 32'd8;
   assign halted     = (state == HALT);

   // Next-state and IF/ID update; priority redirect > stall > fetch.
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      instr_nxt = instr_d;
      pcd_nxt   = pc_d;
      valid_nxt = valid_d;
      fault_nxt = fault_d;
      count_nxt = fetch_count;
      if (redirect_e) begin
         pc_nxt    = {redirect_target_e[31:2], 2'b00};
         valid_nxt = 1'b0;
         fault_nxt = 1'b0;
         state_nxt = RUN;
      end else if (advance) begin
         case (state)
            RUN: begin
               pcd_nxt   = pc;
               valid_nxt = 1'b1;
               count_nxt = fetch_count + 32'd1;
               if (in_range) begin
                  instr_nxt = imem_rd;
                  fault_nxt = 1'b0;
                  pc_nxt    = pc + 32'd4;
               end else begin
                  instr_nxt = NOP_INSTR;
                  fault_nxt = 1'b1;
                  state_nxt = HALT;
               end
            end
            HALT: begin
               valid_nxt = 1'b0;
               fault_nxt = 1'b0;
            end
            default: state_nxt = RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= RUN;
         pc          <= RESET_PC;
         instr_d     <= 32'd0;
         pc_d        <= 32'd0;
         valid_d     <= 1'b0;
         fault_d     <= 1'b0;
         fetch_count <= 32'd0;
      end else begin
         state       <= state_nxt;
         pc          <= pc_nxt;
         instr_d     <= instr_nxt;
         pc_d        <= pcd_nxt;
         valid_d     <= valid_nxt;
         fault_d     <= fault_nxt;
         fetch_count <= count_nxt;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a cycle model pushes expected IF/ID contents
// per driven cycle; they are popped and compared just after each rising edge.
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'hE1A0_0000;

   logic        clk = 1'b0;
   logic        reset, stall_d, redirect_e;
   logic [31:0] redirect_target_e;
   logic [31:0] imem_a, imem_rd, instr_d, pc_d, pc_plus8_d, fetch_count;
   logic        valid_d, fault_d, halted;

   logic [31:0] mem [64];
   assign imem_rd = mem[imem_a[7:2]];

   fetch_stage #(.RESET_PC(32'h0), .IMEM_WORDS(64), .NOP_INSTR(NOP)) dut (
      .clk(clk), .reset(reset), .imem_a(imem_a), .imem_rd(imem_rd),
      .stall_d(stall_d), .redirect_e(redirect_e), .redirect_target_e(redirect_target_e),
      .instr_d(instr_d), .pc_d(pc_d), .pc_plus8_d(pc_plus8_d), .valid_d(valid_d),
      .fault_d(fault_d), .halted(halted), .fetch_count(fetch_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        valid;
      logic        fault;
      logic        halt;
      logic [31:0] a;
      logic [31:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   logic [31:0] m_pc = 0, m_instr = 0, m_pcd = 0, m_cnt = 0;
   logic        m_valid = 0, m_fault = 0, m_halt = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Drive one cycle, predict the post-edge IF/ID state, then compare after the edge.
   task automatic step(input logic r, input logic s, input logic rd, input logic [31:0] t);
      exp_t e, o;
      reset = r; stall_d = s; redirect_e = rd; redirect_target_e = t;
      if (r) begin
         m_pc = 32'h0; m_instr = 0; m_pcd = 0; m_valid = 0; m_fault = 0; m_halt = 0; m_cnt = 0;
      end else if (rd) begin
         m_pc = {t[31:2], 2'b00}; m_valid = 0; m_fault = 0; m_halt = 0;
      end else if (!(s && m_valid)) begin
         if (m_halt) begin
            m_valid = 0; m_fault = 0;
         end else if (m_pc < 32'h100) begin
            m_instr = mem[m_pc[7:2]]; m_pcd = m_pc; m_valid = 1; m_fault = 0;
            m_pc = m_pc + 4; m_cnt = m_cnt + 1;
         end else begin
            m_instr = NOP; m_pcd = m_pc; m_valid = 1; m_fault = 1;
            m_cnt = m_cnt + 1; m_halt = 1;
         end
      end
      e.instr = m_instr; e.pc = m_pcd; e.valid = m_valid; e.fault = m_fault;
      e.halt = m_halt; e.a = m_pc; e.cnt = m_cnt;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      o = exp_q.pop_front();
      check("valid_d", 32'(valid_d), 32'(o.valid));
      check("fault_d", 32'(fault_d), 32'(o.fault));
      check("halted", 32'(halted), 32'(o.halt));
      check("imem_a", imem_a, o.a);
      check("fetch_count", fetch_count, o.cnt);
      if (o.valid) begin
         check("instr_d", instr_d, o.instr);
         check("pc_d", pc_d, o.pc);
         check("pc_plus8_d", pc_plus8_d, o.pc + 32'd8);
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'hE3A0_0000 | 32'(i);
      mem[0] = 32'hE040_0000; mem[1] = 32'hE280_1004; mem[2] = 32'hE280_2004;
      mem[3] = 32'hE151_0002; mem[4] = 32'h0A00_0000; mem[5] = 32'hE081_1002;
      mem[6] = 32'hE171_0002; mem[63] = 32'hE3A0_F0FC;

      // Reset and sequential fetch
      step(1, 0, 0, 0); step(1, 0, 0, 0);
      check("rst_instr", instr_d, 32'h0);
      check("rst_pc", pc_d, 32'h0);
      check("rst_a", imem_a, 32'h0);
      step(0, 0, 0, 0);
      check("seq0", instr_d, 32'hE040_0000);
      check("seq0_p8", pc_plus8_d, 32'h8);
      step(0, 0, 0, 0); step(0, 0, 0, 0);
      check("seq2", instr_d, 32'hE280_2004);

      // Stall for three cycles
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 0, 0);
         check("stall_instr", instr_d, 32'hE280_2004);
         check("stall_pc", pc_d, 32'h8);
         check("stall_a", imem_a, 32'hC);
         check("stall_cnt", fetch_count, 32'd3);
      end
      step(0, 0, 0, 0);
      check("release", instr_d, 32'hE151_0002);
      check("count4", fetch_count, 32'd4);

      // Redirect skipping 0x14; low target bits ignored
      step(0, 0, 0, 0);
      check("pc10", pc_d, 32'h10);
      step(0, 0, 1, 32'h1A);
      check("redir_bubble", 32'(valid_d), 32'd0);
      check("redir_a", imem_a, 32'h18);
      step(0, 0, 0, 0);
      check("redir_instr", instr_d, 32'hE171_0002);
      check("redir_pc", pc_d, 32'h18);

      // Redirect wins over stall
      step(0, 1, 1, 32'h4);
      check("rs_bubble", 32'(valid_d), 32'd0);
      check("rs_a", imem_a, 32'h4);
      step(0, 0, 0, 0);
      check("rs_instr", instr_d, 32'hE280_1004);

      // Out-of-range halt and recovery
      step(0, 0, 1, 32'hFC);
      step(0, 0, 0, 0);
      check("last_pc", pc_d, 32'hFC);
      check("last_fault", 32'(fault_d), 32'd0);
      step(0, 0, 0, 0);
      check("nop_instr", instr_d, NOP);
      check("nop_fault", 32'(fault_d), 32'd1);
      check("nop_pc", pc_d, 32'h100);
      check("nop_halted", 32'(halted), 32'd1);
      step(0, 0, 0, 0);
      step(0, 1, 0, 0);
      check("halt_valid", 32'(valid_d), 32'd0);
      step(0, 0, 1, 32'h0);
      check("unhalt", 32'(halted), 32'd0);
      step(0, 0, 0, 0);
      check("refetch", instr_d, 32'hE040_0000);

      // Reset while halted and stalled, together with a redirect
      step(0, 0, 1, 32'hFC); step(0, 0, 0, 0); step(0, 0, 0, 0);
      step(0, 1, 0, 0);
      check("hs_halted", 32'(halted), 32'd1);
      step(1, 1, 1, 32'h40);
      check("mid_rst_halted", 32'(halted), 32'd0);
      check("mid_rst_a", imem_a, 32'h0);
      check("mid_rst_instr", instr_d, 32'h0);
      check("mid_rst_pc", pc_d, 32'h0);
      check("mid_rst_cnt", fetch_count, 32'd0);
      step(0, 0, 0, 0);
      check("post_rst", instr_d, 32'hE040_0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage for the pipelined SimpleARM core. It owns the program counter and drives the word address into the combinational instruction memory, which returns `rd` in the same cycle. It registers the returned word, with its PC, into the IF/ID pipeline register consumed by decode. It also handles:

- decode back-pressure (stall),
- execute-stage redirects (B/BL/taken branches),
- an out-of-range fetch halt.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `IMEM_WORDS`, 64, number of valid instruction words; fetches at word index ≥ this fault.
- `NOP_INSTR`, 32'hE1A00000, instruction injected on fault (MOV R0,R0).

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `imem_a`  out  32  fetch address, always equal to the PC register (combinational).
- `imem_rd`  in  32  instruction word from instruction memory for `imem_a`, same cycle.
- `stall_d`  in  1  decode cannot accept; hold the IF/ID register if it holds a valid instruction.
- `redirect_e`  in  1  execute requests PC redirect this cycle.
- `redirect_target_e`  in  32  redirect byte address; bits [1:0] ignored.
- `instr_d`  out  32  registered instruction to decode.
- `pc_d`  out  32  byte address of `instr_d`.
- `pc_plus8_d`  out  32  `pc_d`+8 (ARM R15 read value), combinational from `pc_d`.
- `valid_d`  out  1  `instr_d` is a real instruction.
- `fault_d`  out  1  `instr_d` is the injected NOP from an out-of-range fetch.
- `halted`  out  1  FSM in HALT.
- `fetch_count`  out  32  number of instructions accepted into IF/ID since reset.

## Operation
- FSM states: RUN, HALT. Reset state is RUN.
- Reset values:
  - PC = `RESET_PC`; `instr_d` = 0; `pc_d` = 0; `valid_d` = 0; `fault_d` = 0; `fetch_count` = 0.
  - `halted` = 0.
  - `imem_a` = `RESET_PC` in the cycle after reset.
- "Advance" = `!stall_d || !valid_d`. Bubbles never block fetch.
- Priority each edge is reset > redirect > stall > fetch. The rules below are listed in that order.
- **Redirect** (`redirect_e`=1, either state):
  - PC ← {target[31:2],2'b00}; `valid_d` ← 0; `fault_d` ← 0; state ← RUN.
  - `instr_d`/`pc_d` are don't-care but held.
  - Redirect overrides `stall_d`; the flushed slot is discarded.
- **RUN, advance, in range** (PC[31:2] < `IMEM_WORDS`):
  - `instr_d` ← `imem_rd`; `pc_d` ← PC; `valid_d` ← 1; `fault_d` ← 0.
  - PC ← PC+4, mod 2^32 (32'hFFFFFFFC wraps to 0).
  - `fetch_count` += 1, mod 2^32.
- **RUN, advance, out of range:**
  - `instr_d` ← `NOP_INSTR`; `pc_d` ← PC; `valid_d` ← 1; `fault_d` ← 1.
  - PC held; `fetch_count` += 1; state ← HALT.
- **RUN or HALT, stalled** (`stall_d` && `valid_d`, no redirect): all registers hold.
- **HALT, advance, no redirect:** `valid_d` ← 0; `fault_d` ← 0; PC held; no count.
- `halted` = (state == HALT). It is a registered state decode, not combinational on inputs.
- Reset asserted mid-stall, mid-halt or together with redirect: reset wins and all values return to reset values.

## Timing
- Fetch latency: the word at `imem_a` in cycle N appears on `instr_d` with `valid_d`=1 in cycle N+1.
- After reset deasserts, `RAM[0]` is on `instr_d` at the first rising edge.
- Redirect penalty:
  - `redirect_e` in cycle N puts the target on `imem_a` in N+1.
  - The target instruction appears on `instr_d` in N+2.
  - Exactly one bubble (`valid_d`=0) occurs in N+1.
- Stall: while `stall_d`=1 and `valid_d`=1, `instr_d`/`pc_d`/`imem_a` are stable. The first edge with `stall_d`=0 accepts the next word.
- Throughput: one instruction per cycle when unstalled.
- No combinational path from `stall_d` or `redirect_e` to any output.

## Test plan
- **Reset/sequential:**
  - Stimulus: memory loaded with E0400000, E2801004, E2802004, E1510002; reset 2 cycles, then release.
  - Required response: `instr_d` sequence E0400000, E2801004, E2802004, E1510002 with `pc_d` 0,4,8,C; `valid_d`=1 throughout.
  - Required response: `pc_plus8_d`=8 at first; `fetch_count`=4.
- **Stall:**
  - Stimulus: assert `stall_d` for 3 cycles while `instr_d`=E2802004.
  - Required response: `instr_d`/`pc_d`=8 held 3 cycles, `imem_a`=C held, count unchanged.
  - Required response: E1510002 appears the cycle after release.
- **Redirect (BEQ skip):**
  - Stimulus: `redirect_e`=1, target=0x18 in the cycle `pc_d`=0x10.
  - Required response: next cycle `valid_d`=0; following cycle `instr_d`=E1710002, `pc_d`=0x18.
  - Required response: the instruction at 0x14 is never valid.
- **Redirect during stall:**
  - Stimulus: `stall_d`=1 and `redirect_e`=1 (target 0x4) in the same cycle.
  - Required response: next cycle `valid_d`=0, `imem_a`=4; then `instr_d`=E2801004.
- **Out-of-range halt:**
  - Stimulus: redirect to 0xFC with `IMEM_WORDS`=64 (last valid word).
  - Required response: valid fetch at 0xFC, then NOP E1A00000 with `fault_d`=1, `pc_d`=0x100.
  - Required response: `halted`=1 and `valid_d`=0 thereafter.
  - Stimulus: redirect to 0.
  - Required response: `halted`=0 and E0400000 is fetched again.
- **Reset mid-operation:**
  - Stimulus: assert `reset` while halted and stalled.
  - Required response: next edge all outputs at reset values and `imem_a`=`RESET_PC`.
